// File: rtl/greenfloat_arbiter.sv
// Round-robin arbiter sharing one greenfloat_core between NREQ requesters.
// One op in flight; result routed back on a registered valid/ready channel.
module greenfloat_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_mode,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [31:0]          rsp_result,
    output logic                 rsp_overflow,
    output logic                 rsp_error,
    output logic                 core_mode,
    output logic [1:0]           core_operation,
    output logic                 core_valid_in,
    output logic [31:0]          core_a32,
    output logic [31:0]          core_b32,
    output logic [15:0]          core_a16,
    output logic [15:0]          core_b16,
    input  logic [31:0]          core_result32,
    input  logic [15:0]          core_result16,
    input  logic                 core_valid_out,
    input  logic                 core_overflow,
    output logic                 busy,
    output logic [CNT_W-1:0]     fp16_ops,
    output logic [CNT_W-1:0]     fp32_ops,
    output logic [CNT_W-1:0]     timeout_cnt
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    last_q, last_d;
    logic [IW-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]    sel;
    logic             found;
    logic             mode_q, mode_d;
    logic [1:0]       op_q, op_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [31:0]      res_q, res_d;
    logic             ovf_q, ovf_d, err_q, err_d;
    logic [CNT_W-1:0] f16_q, f16_d, f32_q, f32_d, to_q, to_d;
    logic             tmo;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // First requester after the last granted one, with wrap
    always_comb begin
        int            idx;
        logic [IW-1:0] cand;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = IW'(idx);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign tmo = (tmr_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        mode_d  = mode_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        tmr_d   = tmr_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        f16_d   = f16_q;
        f32_d   = f32_q;
        to_d    = to_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = sel;
                    mode_d  = req_mode[sel];
                    op_d    = req_op[2*sel +: 2];
                    a_d     = req_a[32*sel +: 32];
                    b_d     = req_b[32*sel +: 32];
                    res_d   = '0;
                    ovf_d   = 1'b0;
                    err_d   = op_d[0];
                    state_d = op_d[0] ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                tmr_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                tmr_d = tmr_q + 1'b1;
                if (core_valid_out) begin
                    res_d   = mode_q ? {16'h0, core_result16}
                                     : core_result32;
                    ovf_d   = core_overflow;
                    err_d   = 1'b0;
                    state_d = RESP;
                    if (mode_q) f16_d = sat_inc(f16_q);
                    else        f32_d = sat_inc(f32_q);
                end else if (tmo) begin
                    res_d   = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b1;
                    to_d    = sat_inc(to_q);
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[gnt_q]) begin
                    last_d  = gnt_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= IW'(NREQ - 1);
            gnt_q  <= '0;
            mode_q <= 1'b0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            tmr_q  <= '0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
            f16_q  <= '0;
            f32_q  <= '0;
            to_q   <= '0;
        end else begin
            last_q <= last_d;
            gnt_q  <= gnt_d;
            mode_q <= mode_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            tmr_q  <= tmr_d;
            res_q  <= res_d;
            ovf_q  <= ovf_d;
            err_q  <= err_d;
            f16_q  <= f16_d;
            f32_q  <= f32_d;
            to_q   <= to_d;
        end
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (state_q == IDLE && found && !rst) req_ready[sel] = 1'b1;
        if (state_q == RESP) rsp_valid[gnt_q] = 1'b1;
    end

    assign core_valid_in  = (state_q == ISSUE);
    assign busy           = (state_q != IDLE);
    assign core_mode      = mode_q;
    assign core_operation = op_q;
    assign core_a32       = a_q;
    assign core_b32       = b_q;
    assign core_a16       = a_q[15:0];
    assign core_b16       = b_q[15:0];
    assign rsp_result     = res_q;
    assign rsp_overflow   = ovf_q;
    assign rsp_error      = err_q;
    assign fp16_ops       = f16_q;
    assign fp32_ops       = f32_q;
    assign timeout_cnt    = to_q;

endmodule

// File: tb/tb_greenfloat_arbiter.sv
// Directed bench for greenfloat_arbiter with a scoreboard of expected responses
// and a small behavioural core model answering two cycles after issue.
module tb_greenfloat_arbiter;

    localparam int NREQ = 4;
    localparam int TO   = 8;
    localparam int CW   = 2;

    logic clk = 1'b0;
    logic rst;
    logic [NREQ-1:0]    req_valid, req_ready, req_mode;
    logic [NREQ-1:0]    rsp_valid, rsp_ready;
    logic [2*NREQ-1:0]  req_op;
    logic [32*NREQ-1:0] req_a, req_b;
    logic [31:0] rsp_result;
    logic        rsp_overflow, rsp_error;
    logic        core_mode, core_valid_in;
    logic [1:0]  core_operation;
    logic [31:0] core_a32, core_b32;
    logic [15:0] core_a16, core_b16;
    logic [31:0] core_result32 = '0;
    logic [15:0] core_result16 = '0;
    logic        core_valid_out = 1'b0;
    logic        core_overflow = 1'b0;
    logic        busy;
    logic [CW-1:0] fp16_ops, fp32_ops, timeout_cnt;

    greenfloat_arbiter #(.NREQ(NREQ), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mode(req_mode), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
        .rsp_error(rsp_error),
        .core_mode(core_mode), .core_operation(core_operation),
        .core_valid_in(core_valid_in),
        .core_a32(core_a32), .core_b32(core_b32),
        .core_a16(core_a16), .core_b16(core_b16),
        .core_result32(core_result32), .core_result16(core_result16),
        .core_valid_out(core_valid_out), .core_overflow(core_overflow),
        .busy(busy),
        .fp16_ops(fp16_ops), .fp32_ops(fp32_ops),
        .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    // Core stand-in: recognises the two float cases, otherwise integer math
    function automatic logic [31:0] f32(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        if (op == 2'b00 && a == 32'h3F800000 && b == 32'h40000000)
            return 32'h40400000;
        return (op == 2'b00) ? a + b : a * b;
    endfunction

    function automatic logic [15:0] f16(input logic [1:0] op,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
        if (op == 2'b10 && a == 16'h4000 && b == 16'h4200)
            return 16'h4600;
        return (op == 2'b00) ? a + b : a * b;
    endfunction

    logic core_en = 1'b1;
    logic stray = 1'b0;
    int   ccnt = 0;

    always @(posedge clk) begin
        if (core_valid_in && core_en) begin
            ccnt          <= 2;
            core_result32 <= f32(core_operation, core_a32, core_b32);
            core_result16 <= f16(core_operation, core_a16, core_b16);
            core_overflow <= core_mode ? (core_a16[14:10] == 5'h1F)
                                       : (core_a32[30:23] == 8'hFF);
        end else if (ccnt != 0) begin
            ccnt <= ccnt - 1;
        end
        core_valid_out <= (ccnt == 1) || stray;
    end

    typedef struct {
        int          idx;
        logic        mode;
        logic [1:0]  op;
        logic [31:0] res;
        logic        ovf;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int m16 = 0, m32 = 0, mto = 0;

    function automatic int sinc(input int v);
        return (v < 3) ? v + 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int i, input logic m, input logic [1:0] op,
                            input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.idx = i; e.mode = m; e.op = op;
        e.res = '0; e.ovf = 1'b0; e.err = 1'b1;
        if (!op[0] && !core_en) begin
            mto = sinc(mto);
        end else if (!op[0]) begin
            e.err = 1'b0;
            if (m) begin
                e.res = {16'h0, f16(op, a[15:0], b[15:0])};
                e.ovf = (a[14:10] == 5'h1F);
                m16 = sinc(m16);
            end else begin
                e.res = f32(op, a, b);
                e.ovf = (a[30:23] == 8'hFF);
                m32 = sinc(m32);
            end
        end
        sb.push_back(e);
    endtask

    task automatic set_req(input int i, input logic m, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        req_mode[i]      = m;
        req_op[2*i +: 2] = op;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    // Returns at the negedge after the accepting edge, +1
    task automatic send(input int i, input logic m, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        int n;
        set_req(i, m, op, a, b);
        push_exp(i, m, op, a, b);
        req_valid[i] = 1'b1;
        n = 0;
        #1;
        while (!req_ready[i] && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("req_ready", 32'(req_ready), 32'd1 << i);
        @(negedge clk);
        req_valid[i] = 1'b0;
        #1;
    endtask

    task automatic wait_rsp(output int n);
        exp_t e;
        n = 0;
        while (rsp_valid === '0 && n < 100) begin
            @(negedge clk); #1; n++;
        end
        chk("rsp_seen", 32'(rsp_valid != '0), 32'd1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
            e.idx = 0; e.mode = 0; e.op = 0;
            e.res = 0; e.ovf = 0; e.err = 0;
        end else begin
            e = sb.pop_front();
        end
        chk("rsp_valid", 32'(rsp_valid), 32'd1 << e.idx);
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_overflow", 32'(rsp_overflow), 32'(e.ovf));
        chk("rsp_error", 32'(rsp_error), 32'(e.err));
        chk("core_mode_resp", 32'(core_mode), 32'(e.mode));
        chk("core_op_resp", 32'(core_operation), 32'(e.op));
        rsp_ready = ~(4'b0001 << e.idx);
        @(negedge clk); #1;
        chk("rsp_hold_valid", 32'(rsp_valid), 32'd1 << e.idx);
        chk("rsp_hold_result", rsp_result, e.res);
        rsp_ready = 4'b0001 << e.idx;
        @(negedge clk);
        rsp_ready = '0;
        #1;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_fp16"}, 32'(fp16_ops), 32'(m16));
        chk({tag, "_fp32"}, 32'(fp32_ops), 32'(m32));
        chk({tag, "_to"}, 32'(timeout_cnt), 32'(mto));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        m16 = 0; m32 = 0; mto = 0;
        #1;
    endtask

    initial begin
        int n;
        int order[5];
        order = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        req_valid = '0; req_mode = '0; req_op = '0;
        req_a = '0; req_b = '0; rsp_ready = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_err", 32'(rsp_error), 32'd0);
        chk("rst_cvi", 32'(core_valid_in), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk_cnt("rst");

        // FP32 add on requester 0, single-cycle issue pulse
        send(0, 1'b0, 2'b00, 32'h3F800000, 32'h40000000);
        chk("t1_cvi_hi", 32'(core_valid_in), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        @(negedge clk); #1;
        chk("t1_cvi_lo", 32'(core_valid_in), 32'd0);
        wait_rsp(n);
        chk_cnt("t1");

        // FP16 mul on requester 2, upper operand bits are junk
        send(2, 1'b1, 2'b10, 32'hABCD4000, 32'h12344200);
        chk("t2_mode", 32'(core_mode), 32'd1);
        chk("t2_a16", 32'(core_a16), 32'h4000);
        wait_rsp(n);
        chk_cnt("t2");

        // FP32 add flagged overflow by the core
        send(3, 1'b0, 2'b00, 32'h7F800000, 32'h00000001);
        wait_rsp(n);
        chk_cnt("t3");

        // Illegal ops never reach the core
        send(1, 1'b0, 2'b01, 32'h11111111, 32'h22222222);
        chk("t4_cvi", 32'(core_valid_in), 32'd0);
        wait_rsp(n);
        chk_cnt("t4");
        send(0, 1'b1, 2'b11, 32'h3C003C00, 32'h3C003C00);
        chk("t5_cvi", 32'(core_valid_in), 32'd0);
        wait_rsp(n);
        chk_cnt("t5");

        // Round-robin with all requesters valid; fp32 count saturates at 3
        do_reset();
        set_req(0, 1'b0, 2'b00, 32'd1, 32'd2);
        set_req(1, 1'b1, 2'b10, 32'd3, 32'd5);
        set_req(2, 1'b0, 2'b10, 32'd6, 32'd7);
        set_req(3, 1'b0, 2'b00, 32'h100, 32'h200);
        req_valid = 4'hF;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            #1;
            while (req_ready == '0 && n < 100) begin
                @(negedge clk); #1; n++;
            end
            chk("rr_grant", 32'(req_ready), 32'd1 << order[g]);
            push_exp(order[g], req_mode[order[g]],
                     req_op[2*order[g] +: 2],
                     req_a[32*order[g] +: 32], req_b[32*order[g] +: 32]);
            @(negedge clk);
            if (g == 4) req_valid = '0;
            #1;
            chk("rr_no_ready", 32'(req_ready), 32'd0);
            wait_rsp(n);
        end
        chk_cnt("rr");

        // Core silent: timeout after TO wait cycles
        core_en = 1'b0;
        send(3, 1'b0, 2'b00, 32'h1, 32'h2);
        wait_rsp(n);
        chk("to_latency", 32'(n), 32'd9);
        chk_cnt("to");
        core_en = 1'b1;
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        @(negedge clk); #1;
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_rsp", 32'(rsp_valid), 32'd0);
        chk_cnt("stray");

        // Reset while a response is pending
        send(1, 1'b0, 2'b00, 32'd10, 32'd20);
        n = 0;
        while (rsp_valid == '0 && n < 100) begin
            @(negedge clk); #1; n++;
        end
        chk("rr_pend", 32'(rsp_valid), 32'h2);
        repeat (10) @(negedge clk);
        #1;
        chk("rr_pend_hold", 32'(rsp_valid), 32'h2);
        do_reset();
        chk("prst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("prst_result", rsp_result, 32'd0);
        chk("prst_busy", 32'(busy), 32'd0);
        chk("prst_opmode", {29'd0, core_mode, core_operation}, 32'd0);
        chk_cnt("prst");
        set_req(0, 1'b0, 2'b10, 32'd9, 32'd9);
        req_valid = 4'b1101;
        #1;
        chk("prst_grant0", 32'(req_ready), 32'd1);
        push_exp(0, 1'b0, 2'b10, 32'd9, 32'd9);
        @(negedge clk);
        req_valid = '0;
        #1;
        wait_rsp(n);
        chk_cnt("prst_op");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/greenfloat_arbiter.md
Name: greenfloat_arbiter

Overview:
Shares one greenfloat_core between NREQ independent requesters with round-robin arbitration.
- Exactly one operation is in flight at a time.
- The core's output mux selects on its live mode/operation inputs, so the arbiter holds both stable from issue until the result returns.
- Routes each result back to its requester on a valid/ready response channel.
- Keeps FP16/FP32 operation counts and a timeout count for the energy-reporting logic.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 64, WAIT cycles without core_valid_out before the op is abandoned
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  NREQ  request valid, one bit per requester
req_ready  out  NREQ  request accepted (one-hot or zero)
req_mode  in  NREQ  per-requester mode: 0=FP32, 1=FP16
req_op  in  2*NREQ  per-requester operation: 00=add, 10=mul; slice i = [2i+1:2i]
req_a  in  32*NREQ  operand A; FP16 uses bits [15:0] of each slice
req_b  in  32*NREQ  operand B, same packing
rsp_valid  out  NREQ  response valid, one-hot to the owning requester
rsp_ready  in  NREQ  response accepted
rsp_result  out  32  result; FP16 results zero-extended
rsp_overflow  out  1  overflow flag from core
rsp_error  out  1  1 = illegal op or timeout
core_mode  out  1  to core mode
core_operation  out  2  to core operation
core_valid_in  out  1  to core valid_in
core_a32, core_b32  out  32  to core FP32 operands
core_a16, core_b16  out  16  to core FP16 operands
core_result32  in  32  from core
core_result16  in  16  from core
core_valid_out  in  1  from core
core_overflow  in  1  from core
busy  out  1  state != IDLE
fp16_ops  out  CNT_W  FP16 ops completed
fp32_ops  out  CNT_W  FP32 ops completed
timeout_cnt  out  CNT_W  timed-out ops

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE, last_grant=NREQ-1.
  - All latched operands, mode and op = 0.
  - All outputs 0: req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_error, core_valid_in, counters.
  - Reset mid-operation abandons the op and sends no response. A core_valid_out arriving after reset is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, the grant g is the first set bit scanning last_grant+1, +2, … with wrap.
  - req_ready[g]=1 combinationally in the same cycle; all other ready bits stay 0.
  - On that edge: latch mode, op, a, b and g.
  - Next state: ISSUE if op is 00 or 10. If op is 01 or 11, go to RESP with result 0, error=1, no core access, no counter increment.
  - No req_valid: stay in IDLE, req_ready=0.
- ISSUE: core_valid_in=1 for exactly one cycle; clear the timer; go to WAIT.
- WAIT:
  - core_valid_in=0; timer increments each cycle.
  - On core_valid_out: capture the result, go to RESP.
    - result = {16'b0, core_result16} if mode=1, else core_result32.
    - overflow = core_overflow; error = 0.
    - Increment fp16_ops or fp32_ops.
  - If the timer reaches TIMEOUT-1 with no core_valid_out: result 0, error=1, increment timeout_cnt, go to RESP.
  - If core_valid_out and timeout happen in the same cycle, core_valid_out wins.
- RESP:
  - rsp_valid[g]=1 and rsp_result/overflow/error held stable until rsp_ready[g]=1.
  - On that edge: last_grant=g, go to IDLE. rsp_ready on other bits is ignored.
  - Response outputs are registered.
- Core operand/mode outputs:
  - core_mode and core_operation are driven from the latched registers in every state, stable from ISSUE through RESP.
  - core_a16/core_b16 = latched a/b [15:0].
- core_valid_out in IDLE, ISSUE or RESP is ignored.
- Counters saturate at all-ones.
- Latency: request handshake at edge T → core_valid_in high in cycle T+1 → core result at T+1+L → rsp_valid from cycle T+2+L. Minimum request-to-request spacing is L+3 cycles.
- Fairness: a continuously asserting requester waits at most NREQ-1 grants.

Test Plan:
- Single FP32 add, req 0, a=0x3F800000, b=0x40000000 → core_valid_in one cycle; rsp_valid[0], rsp_result=0x40400000, error=0, fp32_ops=1.
- FP16 mul, req 2, a=0x4000, b=0x4200 → rsp_result=0x00004600; core_mode=1 and core_operation=10 stable through RESP; fp16_ops=1.
- All 4 req_valid held high after reset → grant order 0,1,2,3,0; each accepted only after the previous rsp handshake.
- Illegal op=01 on req 1 → no core_valid_in; rsp_valid[1] with result 0, error=1; counters unchanged.
- Core model never asserts valid_out, TIMEOUT=8 → rsp error=1, result 0 after 8 WAIT cycles; timeout_cnt=1. A later valid_out is ignored.
- rsp_ready held low 10 cycles, then rst=1 for one cycle in RESP → all outputs 0 next cycle; arbiter resumes with req 0 highest priority.
